// File: rtl/piano_audio_pkg.sv
// Shared constants and FSM state type for the PWM audio output path.
package piano_audio_pkg;
  localparam int SAMPLE_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO; pointers carry an extra wrap bit so full/empty fall out of their difference.
module sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     fill_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_wr, do_rd;

  assign fill_o    = wr_ptr_q - rd_ptr_q;
  assign full_o    = (fill_o == (AW+1)'(DEPTH));
  assign empty_o   = (fill_o == '0);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Requests against a full/empty FIFO are dropped here, so callers need not gate them.
  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end
endmodule

// File: rtl/pwm_audio_out.sv
// Buffers 8-bit samples and plays each as REPEAT periods of 2**SAMPLE_W-clock PWM on a 1-bit pin.
// First sample loads one edge after it lands in an empty FIFO; s_ready drops only when the FIFO is full.
module pwm_audio_out
  import piano_audio_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int REPEAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [SAMPLE_W-1:0]           s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          pwm_out,
  output logic                          sample_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [RW-1:0]       REP_LAST = RW'(REPEAT - 1);
  localparam logic [SAMPLE_W-1:0] CNT_MAX  = '1;

  state_e                state_q, state_d;
  logic [SAMPLE_W-1:0]   cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]   duty_q, duty_d;
  logic [RW-1:0]         rep_q, rep_d;
  logic                  tick_q, tick_d;
  logic                  under_q, under_d;
  logic                  pop;
  logic [SAMPLE_W-1:0]   head;
  logic                  fifo_full, fifo_empty;

  sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (s_valid),
    .wr_data_i (s_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .fill_o    (fill)
  );

  assign s_ready     = !fifo_full;
  assign pwm_out     = (state_q == RUN) && (cnt_q < duty_q);
  assign sample_tick = tick_q;
  assign underrun    = under_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    rep_d   = rep_q;
    pop     = 1'b0;
    tick_d  = 1'b0;
    under_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en && !fifo_empty) begin
          pop     = 1'b1;
          duty_d  = head;
          rep_d   = '0;
          tick_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Duty may only change at the period boundary so a period never glitches.
          if (cnt_q == CNT_MAX) begin
            if (rep_q != REP_LAST) begin
              rep_d = rep_q + 1'b1;
            end else begin
              rep_d = '0;
              if (!fifo_empty) begin
                pop    = 1'b1;
                duty_d = head;
                tick_d = 1'b1;
              end else begin
                under_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      rep_q   <= '0;
      tick_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      rep_q   <= rep_d;
      tick_q  <= tick_d;
      under_q <= under_d;
    end
  end
endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench: a REPEAT=1 instance for most checks and a REPEAT=3 instance for sample hold.
module tb_pwm_audio_out;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, en3 = 1'b0;
  logic [7:0] s_data = '0, s_data3 = '0;
  logic       s_valid = 1'b0, s_valid3 = 1'b0;
  logic       s_ready, pwm_out, sample_tick, underrun;
  logic       s_ready3, pwm_out3, sample_tick3, underrun3;
  logic [2:0] fill, fill3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pwm_audio_out #(.SAMPLE_W(8), .FIFO_DEPTH(4), .REPEAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .pwm_out(pwm_out), .sample_tick(sample_tick),
    .underrun(underrun), .fill(fill)
  );

  pwm_audio_out #(.SAMPLE_W(8), .FIFO_DEPTH(4), .REPEAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .s_data(s_data3), .s_valid(s_valid3),
    .s_ready(s_ready3), .pwm_out(pwm_out3), .sample_tick(sample_tick3),
    .underrun(underrun3), .fill(fill3)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    int         exp_fill;
    int         exp_ready;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; en3 = 1'b0;
    s_valid = 1'b0; s_valid3 = 1'b0; s_data = '0; s_data3 = '0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick1();
  endtask

  // Observes n cycles starting at posedge+1; counts high PWM cycles and output pulses.
  task automatic count_win(input int n, input bit which, output int hi, output int tk,
                           output int ur, output int both);
    hi = 0; tk = 0; ur = 0; both = 0;
    for (int i = 0; i < n; i++) begin
      if (which) begin
        hi += int'(pwm_out3); tk += int'(sample_tick3); ur += int'(underrun3);
        both += int'(sample_tick3 && underrun3);
      end else begin
        hi += int'(pwm_out); tk += int'(sample_tick); ur += int'(underrun);
        both += int'(sample_tick && underrun);
      end
      tick1();
    end
  endtask

  initial begin
    vec_t vecs[6];
    int hi, tk, ur, both;
    int exp_hi[5];

    vecs[0] = '{1'b1, 8'd1, 1, 1};
    vecs[1] = '{1'b1, 8'd2, 2, 1};
    vecs[2] = '{1'b1, 8'd3, 3, 1};
    vecs[3] = '{1'b1, 8'd4, 4, 0};
    vecs[4] = '{1'b1, 8'd5, 4, 0};
    vecs[5] = '{1'b0, 8'd0, 4, 0};
    exp_hi  = '{1, 2, 3, 4, 4};

    // Reset values
    do_reset();
    check("rst_fill", int'(fill), 0);
    check("rst_ready", int'(s_ready), 1);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_tick", int'(sample_tick), 0);
    check("rst_underrun", int'(underrun), 0);

    // REPEAT=3: each sample held for three periods, then en drop stops PWM next clock
    en3 = 1'b1; s_valid3 = 1'b1; s_data3 = 8'd10;
    tick1();
    s_data3 = 8'd20;
    tick1();
    s_valid3 = 1'b0;
    count_win(768, 1'b1, hi, tk, ur, both);
    check("rep3_hi_10", hi, 30);
    check("rep3_tick_10", tk, 1);
    check("rep3_ur_10", ur, 0);
    count_win(256, 1'b1, hi, tk, ur, both);
    check("rep3_hi_20", hi, 20);
    check("rep3_tick_20", tk, 1);
    for (int i = 0; i < 5; i++) tick1();
    check("rep3_pwm_before_dis", int'(pwm_out3), 1);
    en3 = 1'b0;
    tick1();
    check("rep3_pwm_after_dis", int'(pwm_out3), 0);

    // Single sample 64: tick one edge after push, 64/256 duty, then underrun each period end
    do_reset();
    en = 1'b1; s_valid = 1'b1; s_data = 8'd64;
    tick1();
    s_valid = 1'b0;
    check("d64_tick_early", int'(sample_tick), 0);
    check("d64_fill_after_push", int'(fill), 1);
    tick1();
    check("d64_tick", int'(sample_tick), 1);
    check("d64_pwm_first", int'(pwm_out), 1);
    count_win(256, 1'b0, hi, tk, ur, both);
    check("d64_hi_p1", hi, 64);
    check("d64_ur_p1", ur, 0);
    for (int p = 0; p < 2; p++) begin
      count_win(256, 1'b0, hi, tk, ur, both);
      check("d64_hi_held", hi, 64);
      check("d64_ur_once", ur, 1);
      check("d64_no_tick", tk, 0);
    end

    // 0x00 then 0xFF back to back
    do_reset();
    en = 1'b1; s_valid = 1'b1; s_data = 8'h00;
    tick1();
    s_data = 8'hFF;
    tick1();
    s_valid = 1'b0;
    count_win(256, 1'b0, hi, tk, ur, both);
    check("zero_hi", hi, 0);
    check("zero_tick", tk, 1);
    count_win(256, 1'b0, hi, tk, ur, both);
    check("ff_hi", hi, 255);
    check("ff_tick", tk, 1);
    check("ff_both", both, 0);
    count_win(256, 1'b0, hi, tk, ur, both);
    check("ff_hi_held", hi, 255);
    check("ff_ur", ur, 1);

    // Fill while disabled: fifth push dropped; playback order proves which samples stayed
    do_reset();
    foreach (vecs[i]) begin
      s_valid = vecs[i].valid; s_data = vecs[i].data;
      tick1();
      check($sformatf("tbl_fill_%0d", i), int'(fill), vecs[i].exp_fill);
      check($sformatf("tbl_ready_%0d", i), int'(s_ready), vecs[i].exp_ready);
    end
    check("tbl_pwm_idle", int'(pwm_out), 0);
    en = 1'b1;
    tick1();
    for (int p = 0; p < 5; p++) begin
      count_win(256, 1'b0, hi, tk, ur, both);
      check($sformatf("tbl_play_hi_%0d", p), hi, exp_hi[p]);
      check($sformatf("tbl_play_ur_%0d", p), ur, (p == 4) ? 1 : 0);
    end

    // Asynchronous reset mid-RUN with three samples queued
    do_reset();
    en = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'(100 + i);
      tick1();
    end
    s_valid = 1'b0;
    check("arst_pre_fill", int'(fill), 3);
    check("arst_pre_pwm", int'(pwm_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pwm", int'(pwm_out), 0);
    check("arst_fill", int'(fill), 0);
    check("arst_ready", int'(s_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick1();
    tick1();
    check("arst_stays_idle", int'(pwm_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
